// File: rtl/bar_level_if.sv
// bar_level_if: bundles the thermometer input and the decoded level outputs
// of bar_level_decoder. The master side drives bar_in; the slave side (the
// decoder) drives the level, strobe, error and busy signals.
interface bar_level_if;
    logic [15:0] bar_in;
    logic [4:0]  level_out;
    logic        level_valid;
    logic        code_err;
    logic        busy;

    modport master (
        output bar_in,
        input  level_out,
        input  level_valid,
        input  code_err,
        input  busy
    );

    modport slave (
        input  bar_in,
        output level_out,
        output level_valid,
        output code_err,
        output busy
    );
endinterface

// File: rtl/bar_level_decoder.sv
// bar_level_decoder: recovers a 0..16 level from a 16-bit thermometer code.
// The raw input is double-flopped, must stay unchanged for STABLE_CYCLES
// clocks, and is then decoded once. A legal code updates level_out with a
// one-cycle level_valid strobe; an illegal code sets the sticky code_err.
// Optional build macro BAR_BUBBLE_CORRECT_EN: illegal codes are decoded as
// their population count (still flagging code_err) instead of being ignored.
module bar_level_decoder #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    bar_level_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DECODE = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

    // A thermometer code has no zero below its highest one: adding one
    // turns it into a single power of two that shares no bit with it.
    function automatic logic is_thermo(input logic [15:0] code);
        logic [15:0] plus_one;
        plus_one = code + 16'd1;
        return ((code & plus_one) == 16'h0000);
    endfunction

    // Number of set bars; equals the level for every legal code.
    function automatic logic [4:0] count_ones(input logic [15:0] code);
        logic [4:0] total;
        total = 5'd0;
        for (int i = 0; i < 16; i++) begin
            total = total + {4'd0, code[i]};
        end
        return total;
    endfunction

    logic [15:0] sync1_r;
    logic [15:0] sync2_r;
    logic [15:0] bar_prev_r;
    state_t      state_r;
    state_t      state_nx_s;
    logic [7:0]  cnt_r;
    logic [7:0]  cnt_nx_s;
    logic        commit_s;
    logic        chg_s;
    logic [15:0] bar_s;
    logic        dec_legal_s;
    logic [4:0]  dec_level_s;
    logic [4:0]  level_r;
    logic        level_valid_r;
    logic        code_err_r;

    assign bar_s       = sync2_r;
    assign chg_s       = (sync2_r != bar_prev_r);
    assign dec_legal_s = is_thermo(bar_s);
    assign dec_level_s = count_ones(bar_s);

    // Two-stage synchroniser plus one-cycle history for change detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r    <= 16'h0000;
            sync2_r    <= 16'h0000;
            bar_prev_r <= 16'h0000;
        end else begin
            sync1_r    <= bus.bar_in;
            sync2_r    <= sync1_r;
            bar_prev_r <= sync2_r;
        end
    end

    // FSM state and settle counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_SETTLE;
            cnt_r   <= 8'd0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    // Next-state logic: any input change restarts the settle window, and a
    // decode is only committed if the input stayed put through DECODE.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        commit_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (chg_s) begin
                    state_nx_s = ST_SETTLE;
                    cnt_nx_s   = 8'd0;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (chg_s) begin
                    state_nx_s = ST_SETTLE;
                    cnt_nx_s   = 8'd0;
                end else if (cnt_r == CNT_LAST) begin
                    state_nx_s = ST_DECODE;
                    cnt_nx_s   = 8'd0;
                end else begin
                    cnt_nx_s   = cnt_r + 8'd1;
                end
            end
            ST_DECODE: begin
                if (chg_s) begin
                    state_nx_s = ST_SETTLE;
                    cnt_nx_s   = 8'd0;
                end else begin
                    state_nx_s = ST_IDLE;
                    commit_s   = 1'b1;
                end
            end
            default: begin
                state_nx_s = ST_SETTLE;
                cnt_nx_s   = 8'd0;
            end
        endcase
    end

    // Output registers: level/strobe/error updated only on a committed decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_r       <= 5'd0;
            level_valid_r <= 1'b0;
            code_err_r    <= 1'b0;
        end else begin
            level_valid_r <= 1'b0;
            if (commit_s) begin
                if (dec_legal_s) begin
                    if (dec_level_s != level_r) begin
                        level_r       <= dec_level_s;
                        level_valid_r <= 1'b1;
                    end
                    code_err_r <= 1'b0;
                end else begin
`ifdef BAR_BUBBLE_CORRECT_EN
                    if (dec_level_s != level_r) begin
                        level_r       <= dec_level_s;
                        level_valid_r <= 1'b1;
                    end
`endif
                    code_err_r <= 1'b1;
                end
            end
        end
    end

    assign bus.level_out   = level_r;
    assign bus.level_valid = level_valid_r;
    assign bus.code_err    = code_err_r;
    assign bus.busy        = (state_r != ST_IDLE);

endmodule

// File: tb/tb_bar_level_decoder.sv
// tb_bar_level_decoder: drives bar_in as a sequence of held segments. A
// segment held long enough to survive synchronising and settling predicts one
// decode; the predicted pulse (level, error, edge) goes into a scoreboard
// queue that an independent monitor pops whenever level_valid is seen.
module tb_bar_level_decoder;

    localparam int SC = 4;

    typedef struct {
        logic [4:0] level;
        logic       err;
        int         cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    bar_level_if bus ();

    bar_level_decoder #(.STABLE_CYCLES(SC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic        prev_valid = 1'b0;
    logic [4:0]  m_level;
    logic        m_err;
    logic [15:0] last_v;

    // Edge counter used to time-stamp expected pulses.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every level_valid pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && bus.level_valid) begin
            n_checks++;
            if (prev_valid) begin
                n_fail++;
                $display("FAIL back_to_back_pulse: level_valid high two cycles in a row at edge %0d", cyc);
            end else if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: got level=%0d err=%0d at edge %0d, expected no pulse",
                         bus.level_out, bus.code_err, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                if (bus.level_out != mon_e.level || bus.code_err != mon_e.err || cyc != mon_e.cyc) begin
                    n_fail++;
                    $display("FAIL pulse: got level=%0d err=%0d edge=%0d, expected level=%0d err=%0d edge=%0d",
                             bus.level_out, bus.code_err, cyc, mon_e.level, mon_e.err, mon_e.cyc);
                end
            end
        end
        prev_valid <= bus.level_valid;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Level of a thermometer code, or -1 when the pattern is not one.
    function automatic int thermo_level(input logic [15:0] v);
        for (int k = 0; k <= 16; k++) begin
            logic [16:0] t;
            t = (17'd1 << k) - 17'd1;
            if (v == t[15:0]) return k;
        end
        return -1;
    endfunction

    // Reference model of one committed decode of value v.
    task automatic model_apply(input logic [15:0] v, input int when);
        int   k;
        exp_t e;
        logic err;
        k   = thermo_level(v);
        err = (k < 0);
        if (err) begin
`ifdef BAR_BUBBLE_CORRECT_EN
            k = $countones(v);
`else
            k = int'(m_level);
`endif
        end
        if (k != int'(m_level)) begin
            e.level = 5'(k);
            e.err   = err;
            e.cyc   = when;
            sb_q.push_back(e);
            m_level = 5'(k);
        end
        m_err = err;
    endtask

    // Drive v (a change from the current input) for len edges, starting
    // from a negative edge so the next rising edge is the first to sample it.
    task automatic seg(input logic [15:0] v, input int len);
        int start;
        start      = cyc;
        bus.bar_in = v;
        last_v     = v;
        if (len >= SC + 2) model_apply(v, start + SC + 4);
        for (int i = 0; i < len; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 2) check("busy_settling", int'(bus.busy), 1);
            if (i == SC + 3) begin
                check("level_steady", int'(bus.level_out), int'(m_level));
                check("code_err_steady", int'(bus.code_err), int'(m_err));
                check("busy_idle", int'(bus.busy), 0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] v;
        logic [16:0] t;
        int          len;

        rst        = 1'b1;
        bus.bar_in = 16'h0000;
        last_v     = 16'h0000;
        m_level    = 5'd0;
        m_err      = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_level", int'(bus.level_out), 0);
        check("reset_valid", int'(bus.level_valid), 0);
        check("reset_err", int'(bus.code_err), 0);
        check("reset_busy", int'(bus.busy), 1);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("idle_zero_level", int'(bus.level_out), 0);
        check("idle_zero_err", int'(bus.code_err), 0);
        check("idle_zero_busy", int'(bus.busy), 0);

        // Basic decodes.
        seg(16'h00FF, 12);
        seg(16'hFFFF, 12);

        // Fast toggling never settles; the final hold decodes once.
        for (int i = 0; i < 15; i++) seg((i % 2 == 0) ? 16'h0007 : 16'h000F, 2);
        seg(16'h000F, 12);

        // Illegal pattern, then recovery.
        seg(16'h001F, 12);
        seg(16'h00F5, 12);
        seg(16'h0003, 12);

        // Re-applying the current level through a short detour.
        seg(16'h001F, 12);
        seg(16'h003F, 2);
        seg(16'h001F, 2);
        seg(16'h003F, 2);
        seg(16'h001F, 12);

        // Randomised segments: mix of legal codes and arbitrary patterns.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                t = (17'd1 << $urandom_range(0, 16)) - 17'd1;
                v = t[15:0];
            end else begin
                v = 16'($urandom);
            end
            if (v == last_v) v = ~v;
            len = $urandom_range(1, 12);
            seg(v, len);
        end
        seg((last_v == 16'h0003) ? 16'h0007 : 16'h0003, 12);

        // Asynchronous reset while settling.
        seg(16'h01FF, 12);
        check("pre_reset_level", int'(bus.level_out), 9);
        bus.bar_in = 16'h0001;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pre_reset_busy", int'(bus.busy), 1);
        #2;
        rst        = 1'b1;
        bus.bar_in = 16'h0000;
        #1;
        check("async_reset_level", int'(bus.level_out), 0);
        check("async_reset_err", int'(bus.code_err), 0);
        check("async_reset_valid", int'(bus.level_valid), 0);
        check("async_reset_busy", int'(bus.busy), 1);
        check("queue_empty_at_reset", sb_q.size(), 0);
        sb_q.delete();
        m_level = 5'd0;
        m_err   = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("post_reset_level", int'(bus.level_out), 0);
        check("post_reset_err", int'(bus.code_err), 0);
        check("post_reset_busy", int'(bus.busy), 0);

        for (int i = 0; i < 30; i++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk);
        end
        check("scoreboard_drain", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
